// File: rtl/tdes_ahb_slave_fifo.sv
// rtl/tdes_ahb_slave_fifo.sv - AHB-Lite register slave feeding a TDES core through input/output FIFOs
//
// Register map (index = HADDR - BASE_ADDR):
//   0              CTRL   RW  [0] mode, [1] flush strobe, [2] clear-sticky strobe
//   1..NUM_KEYS    KEYn   RW  key registers
//   NUM_KEYS+1     DIN    W   push into input FIFO
//   NUM_KEYS+2     DOUT   R   pop from output FIFO (0 + underflow when empty)
//   NUM_KEYS+3     STATUS R   FIFO flags, sticky flags, counts
//
// Optional macro TDES_AHB_WAIT_EN: a DIN write to a full input FIFO inserts wait
// states until the core frees an entry. Without it the write completes and the
// data is dropped with the sticky overflow flag set.
//
// Ports:
//   HCLK, HRESET (async, active-low)      clock / reset
//   HSEL..HWDATA                          AHB-Lite slave inputs
//   HRDATA, HREADYOUT, HRESP              AHB-Lite slave outputs
//   core_valid/core_ready/core_data       input FIFO head towards the core
//   core_mode, core_keys                  CTRL.mode and key registers (key1 in LSBs)
//   res_valid/res_data/res_ready          core results into the output FIFO
module tdes_ahb_slave_fifo #(
    parameter int          DATA_W     = 64,
    parameter int          NUM_KEYS   = 3,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'hAAAAAAA0
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic                         HSEL,
    input  logic                         HWRITE,
    input  logic                         HMASTLOCK,
    input  logic                         HREADY,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [3:0]                   HPROT,
    input  logic [DATA_W-1:0]            HWDATA,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADYOUT,
    output logic                         HRESP,
    output logic                         core_valid,
    input  logic                         core_ready,
    output logic [DATA_W-1:0]            core_data,
    output logic                         core_mode,
    output logic [NUM_KEYS*DATA_W-1:0]   core_keys,
    input  logic                         res_valid,
    input  logic [DATA_W-1:0]            res_data,
    output logic                         res_ready
);
    localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW       = PW + 1;
    localparam logic [2:0]    SIZE_OK  = 3'($clog2(DATA_W / 8));
    localparam logic [2:0]    IDX_CTRL = 3'd0;
    localparam logic [2:0]    IDX_DIN  = 3'(NUM_KEYS + 1);
    localparam logic [2:0]    IDX_DOUT = 3'(NUM_KEYS + 2);
    localparam logic [2:0]    IDX_STAT = 3'(NUM_KEYS + 3);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_ERR1, ST_ERR2} state_t;

    state_t             state_q, state_d;
    logic               dp_write_q, dp_write_d;
    logic [2:0]         dp_idx_q, dp_idx_d;

    logic [31:0]        addr_off;
    logic               addr_err, accept, take, stall, xfer_done;
    logic               wr_en, rd_en, ctrl_we, fifo_flush, sticky_clr;
    logic               din_we, dout_re;

    logic               mode_q;
    logic [DATA_W-1:0]  key_q [NUM_KEYS];
    logic               ovf_q, unf_q;
    logic [DATA_W-1:0]  rdata_q, rd_mux;
    logic [31:0]        status_w;

    logic [DATA_W-1:0]  in_mem  [FIFO_DEPTH];
    logic [DATA_W-1:0]  out_mem [FIFO_DEPTH];
    logic [PW-1:0]      in_wr_q, in_rd_q, out_wr_q, out_rd_q;
    logic [CW-1:0]      in_cnt_q, out_cnt_q;
    logic               in_empty, in_full, out_empty, out_full;
    logic               in_push, in_pop, out_push, out_pop;

    logic               unused_ok;
    assign unused_ok = ^{HPROT, HTRANS[0]};

    // Address-phase decode; an offset below BASE_ADDR wraps to a large value and is unmapped.
    assign addr_off = HADDR - BASE_ADDR;
    assign accept   = HSEL && HREADY && HTRANS[1];

    always_comb begin
        addr_err = 1'b0;
        if (addr_off > 32'(NUM_KEYS + 3))
            addr_err = 1'b1;
        if (HSIZE != SIZE_OK || HBURST != 3'd0 || HMASTLOCK)
            addr_err = 1'b1;
        if (HWRITE && (addr_off[2:0] == IDX_DOUT || addr_off[2:0] == IDX_STAT))
            addr_err = 1'b1;
        if (!HWRITE && addr_off[2:0] == IDX_DIN)
            addr_err = 1'b1;
    end

`ifdef TDES_AHB_WAIT_EN
    assign stall = (state_q == ST_XFER) && dp_write_q && (dp_idx_q == IDX_DIN) && in_full;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q    <= ST_IDLE;
            dp_write_q <= 1'b0;
            dp_idx_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dp_write_d = dp_write_q;
        dp_idx_d   = dp_idx_q;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        case (state_q)
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: HRESP = 1'b1;
            ST_XFER: if (stall) HREADYOUT = 1'b0;
            default: ;
        endcase
        // A new address phase is only taken in cycles where this slave completes its data phase.
        take = accept && HREADYOUT;
        if (HREADYOUT) begin
            if (take) begin
                state_d    = addr_err ? ST_ERR1 : ST_XFER;
                dp_write_d = HWRITE;
                dp_idx_d   = addr_off[2:0];
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign xfer_done  = (state_q == ST_XFER) && !stall;
    assign wr_en      = xfer_done && dp_write_q;
    assign rd_en      = xfer_done && !dp_write_q;
    assign ctrl_we    = wr_en && (dp_idx_q == IDX_CTRL);
    assign fifo_flush = ctrl_we && HWDATA[1];
    assign sticky_clr = ctrl_we && HWDATA[2];
    assign din_we     = wr_en && (dp_idx_q == IDX_DIN);
    assign dout_re    = rd_en && (dp_idx_q == IDX_DOUT);

    assign in_empty  = (in_cnt_q == '0);
    assign in_full   = (in_cnt_q == FULL_CNT);
    assign out_empty = (out_cnt_q == '0);
    assign out_full  = (out_cnt_q == FULL_CNT);

    assign in_push  = din_we && !in_full;
    assign in_pop   = core_valid && core_ready;
    assign out_push = res_valid && res_ready;
    assign out_pop  = dout_re && !out_empty;

    assign core_valid = !in_empty;
    assign core_data  = in_mem[in_rd_q];
    assign res_ready  = !out_full;
    assign core_mode  = mode_q;

    always_comb begin
        core_keys = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            core_keys[k*DATA_W +: DATA_W] = key_q[k];
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            mode_q <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++)
                key_q[k] <= '0;
        end else begin
            if (ctrl_we)
                mode_q <= HWDATA[0];
            for (int k = 0; k < NUM_KEYS; k++)
                if (wr_en && dp_idx_q == 3'(k + 1))
                    key_q[k] <= HWDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (sticky_clr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (din_we && in_full)
                ovf_q <= 1'b1;
            if (dout_re && out_empty)
                unf_q <= 1'b1;
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge HCLK) begin
        if (in_push)
            in_mem[in_wr_q] <= HWDATA;
        if (out_push)
            out_mem[out_wr_q] <= res_data;
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            in_cnt_q <= '0;
        end else if (fifo_flush) begin
            in_wr_q  <= '0;
            in_rd_q  <= '0;
            in_cnt_q <= '0;
        end else begin
            if (in_push)
                in_wr_q <= in_wr_q + 1'b1;
            if (in_pop)
                in_rd_q <= in_rd_q + 1'b1;
            if (in_push && !in_pop)
                in_cnt_q <= in_cnt_q + 1'b1;
            else if (!in_push && in_pop)
                in_cnt_q <= in_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
        end else if (fifo_flush) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (out_push)
                out_wr_q <= out_wr_q + 1'b1;
            if (out_pop)
                out_rd_q <= out_rd_q + 1'b1;
            if (out_push && !out_pop)
                out_cnt_q <= out_cnt_q + 1'b1;
            else if (!out_push && out_pop)
                out_cnt_q <= out_cnt_q - 1'b1;
        end
    end

    assign status_w = {8'd0, 8'(out_cnt_q), 8'(in_cnt_q), 2'b00,
                       unf_q, ovf_q, out_full, out_empty, in_full, in_empty};

    always_comb begin
        rd_mux = '0;
        if (dp_idx_q == IDX_CTRL)
            rd_mux[0] = mode_q;
        else if (dp_idx_q == IDX_DOUT)
            rd_mux = out_empty ? '0 : out_mem[out_rd_q];
        else if (dp_idx_q == IDX_STAT)
            rd_mux = DATA_W'(status_w);
        else
            for (int k = 0; k < NUM_KEYS; k++)
                if (dp_idx_q == 3'(k + 1))
                    rd_mux = key_q[k];
    end

    // Read data is live during a read data phase and otherwise holds the last value driven.
    assign HRDATA = (state_q == ST_XFER && !dp_write_q) ? rd_mux : rdata_q;

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET)
            rdata_q <= '0;
        else
            rdata_q <= HRDATA;
    end
endmodule

// File: tb/tb_tdes_ahb_slave_fifo.sv
// tb/tb_tdes_ahb_slave_fifo.sv - directed self-checking bench for tdes_ahb_slave_fifo
module tb_tdes_ahb_slave_fifo;
    localparam int          DW   = 64;
    localparam int          NK   = 3;
    localparam int          FD   = 4;
    localparam logic [31:0] BASE = 32'hAAAAAAA0;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_KEY1 = BASE + 32'd1;
    localparam logic [31:0] A_KEY2 = BASE + 32'd2;
    localparam logic [31:0] A_KEY3 = BASE + 32'd3;
    localparam logic [31:0] A_DIN  = BASE + 32'd4;
    localparam logic [31:0] A_DOUT = BASE + 32'd5;
    localparam logic [31:0] A_STAT = BASE + 32'd6;
    localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h23456789ABCDEF01;
    localparam logic [63:0] K3 = 64'h456789ABCDEF0123;

    logic              HCLK = 1'b0;
    logic              HRESET = 1'b0;
    logic              HSEL = 1'b0, HWRITE = 1'b0, HMASTLOCK = 1'b0;
    wire               HREADY;
    logic [31:0]       HADDR = '0;
    logic [1:0]        HTRANS = '0;
    logic [2:0]        HSIZE = 3'd3, HBURST = '0;
    logic [3:0]        HPROT = 4'h3;
    logic [DW-1:0]     HWDATA = '0;
    logic [DW-1:0]     HRDATA;
    logic              HREADYOUT, HRESP;
    logic              core_valid, core_ready = 1'b0, core_mode;
    logic [DW-1:0]     core_data;
    logic [NK*DW-1:0]  core_keys;
    logic              res_valid = 1'b0, res_ready;
    logic [DW-1:0]     res_data = '0;

    int total = 0;
    int bad = 0;
    logic [63:0] rd;
    logic        er, wresp;
    int          wt;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    tdes_ahb_slave_fifo #(.DATA_W(DW), .NUM_KEYS(NK), .FIFO_DEPTH(FD), .BASE_ADDR(BASE)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .core_valid(core_valid), .core_ready(core_ready), .core_data(core_data),
        .core_mode(core_mode), .core_keys(core_keys), .res_valid(res_valid),
        .res_data(res_data), .res_ready(res_ready)
    );

    // One non-pipelined transfer; returns at #1 after the edge that completes the data phase.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output logic werr, output int waits);
        logic done;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        waits = 0; err = 1'b0; werr = 1'b0; rdata = '0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                rdata = HRDATA; err = HRESP; done = 1'b1;
            end else begin
                waits++; werr = HRESP;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL xfer_timeout addr=%h no HREADYOUT within 60 cycles", addr);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b0;
        repeat (3) @(negedge HCLK);
        total++; if (HREADYOUT !== 1'b1) begin bad++; $display("FAIL rst_hreadyout got=%b exp=1", HREADYOUT); end
        total++; if (HRESP !== 1'b0) begin bad++; $display("FAIL rst_hresp got=%b exp=0", HRESP); end
        total++; if (HRDATA !== '0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
        total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL rst_core_valid got=%b exp=0", core_valid); end
        total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL rst_res_ready got=%b exp=1", res_ready); end
        total++; if (core_mode !== 1'b0) begin bad++; $display("FAIL rst_core_mode got=%b exp=0", core_mode); end
        total++; if (core_keys !== '0) begin bad++; $display("FAIL rst_core_keys got=%h exp=0", core_keys); end
        @(posedge HCLK); #2; HRESET = 1'b1;
    endtask

    task automatic test_keys();
        xfer(1'b1, A_KEY1, 3'd3, K1, rd, er, wresp, wt);
        xfer(1'b1, A_KEY2, 3'd3, K2, rd, er, wresp, wt);
        xfer(1'b1, A_KEY3, 3'd3, K3, rd, er, wresp, wt);
        xfer(1'b1, A_CTRL, 3'd3, 64'h1, rd, er, wresp, wt);
        total++; if (core_keys !== {K3, K2, K1}) begin bad++; $display("FAIL keys_out got=%h exp=%h", core_keys, {K3, K2, K1}); end
        total++; if (core_mode !== 1'b1) begin bad++; $display("FAIL keys_mode got=%b exp=1", core_mode); end
        xfer(1'b0, A_KEY2, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== K2 || er !== 1'b0 || wt != 0) begin bad++; $display("FAIL key2_read got=%h err=%b waits=%0d exp=%h err=0 waits=0", rd, er, wt, K2); end
        xfer(1'b0, A_CTRL, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h1) begin bad++; $display("FAIL ctrl_read got=%h exp=1", rd); end
    endtask

    task automatic test_error();
        logic        e_wr;
        logic [31:0] e_addr;
        xfer(1'b1, A_KEY1, 3'b010, 64'hDEADBEEFDEADBEEF, rd, er, wresp, wt);
        total++; if (wt != 1 || wresp !== 1'b1 || er !== 1'b1) begin bad++; $display("FAIL size_err waits=%0d first_resp=%b last_resp=%b exp 1/1/1", wt, wresp, er); end
        xfer(1'b0, A_KEY1, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== K1 || er !== 1'b0 || wt != 0) begin bad++; $display("FAIL key1_unchanged got=%h err=%b waits=%0d exp=%h", rd, er, wt, K1); end
        for (int i = 0; i < 7; i++) begin
            e_wr = 1'b0; e_addr = A_CTRL;
            case (i)
                0: HBURST = 3'b001;
                1: HMASTLOCK = 1'b1;
                2: begin e_wr = 1'b1; e_addr = A_DOUT; end
                3: begin e_wr = 1'b1; e_addr = A_STAT; end
                4: e_addr = A_DIN;
                5: e_addr = BASE + 32'd7;
                default: e_addr = BASE - 32'd1;
            endcase
            xfer(e_wr, e_addr, 3'd3, 64'h1234, rd, er, wresp, wt);
            HBURST = 3'd0; HMASTLOCK = 1'b0;
            total++; if (wt != 1 || wresp !== 1'b1 || er !== 1'b1) begin bad++; $display("FAIL err_case%0d waits=%0d first_resp=%b last_resp=%b exp 1/1/1", i, wt, wresp, er); end
        end
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = A_DOUT;
        @(negedge HCLK);
        total++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin bad++; $display("FAIL busy_ignored rdy=%b resp=%b exp 1/0", HREADYOUT, HRESP); end
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h5 || er !== 1'b0) begin bad++; $display("FAIL err_no_side_effect status=%h exp=5", rd); end
    endtask

    task automatic test_din_fill();
        logic [63:0] first;
        core_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            xfer(1'b1, A_DIN, 3'd3, {32'hD1D1D1D1, 32'(i)}, rd, er, wresp, wt);
        total++; if (core_valid !== 1'b1 || core_data !== {32'hD1D1D1D1, 32'd0}) begin bad++; $display("FAIL din_head valid=%b data=%h", core_valid, core_data); end
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h406) begin bad++; $display("FAIL din_full_status got=%h exp=406", rd); end
`ifdef TDES_AHB_WAIT_EN
        fork
            xfer(1'b1, A_DIN, 3'd3, {32'hD1D1D1D1, 32'd4}, rd, er, wresp, wt);
            begin
                repeat (4) @(negedge HCLK);
                core_ready = 1'b1;
                @(negedge HCLK);
                core_ready = 1'b0;
            end
        join
        total++; if (wt != 3 || er !== 1'b0) begin bad++; $display("FAIL din_stall waits=%0d err=%b exp 3/0", wt, er); end
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h406) begin bad++; $display("FAIL din_after_stall status=%h exp=406", rd); end
        first = {32'hD1D1D1D1, 32'd1};
`else
        xfer(1'b1, A_DIN, 3'd3, {32'hD1D1D1D1, 32'd4}, rd, er, wresp, wt);
        total++; if (wt != 0 || er !== 1'b0) begin bad++; $display("FAIL din_overflow_xfer waits=%0d err=%b exp 0/0", wt, er); end
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h416) begin bad++; $display("FAIL din_overflow_status got=%h exp=416", rd); end
        first = {32'hD1D1D1D1, 32'd0};
`endif
        core_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            total++; if (core_valid !== 1'b1 || core_data !== first + 64'(i)) begin bad++; $display("FAIL drain%0d valid=%b got=%h exp=%h", i, core_valid, core_data, first + 64'(i)); end
        end
        @(negedge HCLK);
        core_ready = 1'b0;
        total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL drain_empty valid=%b exp=0", core_valid); end
        xfer(1'b1, A_CTRL, 3'd3, 64'h5, rd, er, wresp, wt);
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h5 || core_mode !== 1'b1) begin bad++; $display("FAIL clear_sticky status=%h mode=%b exp 5/1", rd, core_mode); end
    endtask

    task automatic test_dout();
        @(negedge HCLK); res_valid = 1'b1; res_data = 64'hA5A5A5A5A5A5A5A5;
        @(negedge HCLK); res_data = 64'h5A5A5A5A5A5A5A5A;
        @(negedge HCLK); res_valid = 1'b0;
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h20001) begin bad++; $display("FAIL dout_status got=%h exp=20001", rd); end
        xfer(1'b0, A_DOUT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'hA5A5A5A5A5A5A5A5 || wt != 0) begin bad++; $display("FAIL dout_first got=%h waits=%0d", rd, wt); end
        xfer(1'b0, A_DOUT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h5A5A5A5A5A5A5A5A) begin bad++; $display("FAIL dout_second got=%h", rd); end
        @(negedge HCLK);
        total++; if (HRDATA !== 64'h5A5A5A5A5A5A5A5A) begin bad++; $display("FAIL hrdata_hold got=%h exp=5a5a5a5a5a5a5a5a", HRDATA); end
        xfer(1'b0, A_DOUT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h0 || er !== 1'b0 || wt != 0) begin bad++; $display("FAIL dout_underflow got=%h err=%b waits=%0d", rd, er, wt); end
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h25) begin bad++; $display("FAIL underflow_status got=%h exp=25", rd); end
        xfer(1'b1, A_CTRL, 3'd3, 64'h5, rd, er, wresp, wt);
    endtask

    task automatic test_flush();
        xfer(1'b1, A_DIN, 3'd3, 64'h11, rd, er, wresp, wt);
        xfer(1'b1, A_DIN, 3'd3, 64'h22, rd, er, wresp, wt);
        @(negedge HCLK); res_valid = 1'b1; res_data = 64'h77;
        @(negedge HCLK); res_valid = 1'b0;
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h10200) begin bad++; $display("FAIL preflush_status got=%h exp=10200", rd); end
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_CTRL; HWRITE = 1'b1; HSIZE = 3'd3;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 64'h3;
        core_ready = 1'b1; res_valid = 1'b1; res_data = 64'h99;
        @(posedge HCLK); #1;
        core_ready = 1'b0; res_valid = 1'b0;
        total++; if (core_valid !== 1'b0 || res_ready !== 1'b1) begin bad++; $display("FAIL flush_empty core_valid=%b res_ready=%b exp 0/1", core_valid, res_ready); end
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h5) begin bad++; $display("FAIL flush_status got=%h exp=5", rd); end
        xfer(1'b0, A_CTRL, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h1) begin bad++; $display("FAIL ctrl_strobe_read got=%h exp=1", rd); end
    endtask

    task automatic test_reset_stall();
        core_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            xfer(1'b1, A_DIN, 3'd3, 64'(i + 100), rd, er, wresp, wt);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_DIN; HWRITE = 1'b1; HSIZE = 3'd3;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 64'h55;
        @(negedge HCLK);
`ifdef TDES_AHB_WAIT_EN
        total++; if (HREADYOUT !== 1'b0) begin bad++; $display("FAIL stall_before_reset rdy=%b exp=0", HREADYOUT); end
`endif
        HRESET = 1'b0;
        #1;
        total++; if (HREADYOUT !== 1'b1 || core_valid !== 1'b0 || res_ready !== 1'b1) begin bad++; $display("FAIL mid_reset rdy=%b core_valid=%b res_ready=%b exp 1/0/1", HREADYOUT, core_valid, res_ready); end
        @(posedge HCLK); #2; HRESET = 1'b1;
        xfer(1'b0, A_STAT, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h5 || er !== 1'b0 || wt != 0) begin bad++; $display("FAIL post_reset_status got=%h err=%b waits=%0d exp=5", rd, er, wt); end
        xfer(1'b0, A_KEY1, 3'd3, '0, rd, er, wresp, wt);
        total++; if (rd !== 64'h0 || core_mode !== 1'b0) begin bad++; $display("FAIL post_reset_key1 got=%h mode=%b exp 0/0", rd, core_mode); end
    endtask

    initial begin
        test_reset();
        test_keys();
        test_error();
        test_din_fill();
        test_dout();
        test_flush();
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
